// File: rtl/rv_core_pkg.sv
// Shared definitions for the fetch stage.
//   DefaultPcW    : default word-index PC width
//   InsnNop       : ADDI x0,x0,0, used as the IF/ID reset value
//   InsnEcall     : ECALL encoding, recognised when FETCH_HALT_EN is defined
//   fetch_state_e : fetch FSM states
package rv_core_pkg;

  localparam int unsigned DefaultPcW = 10;

  localparam logic [31:0] InsnNop   = 32'h0000_0013;
  localparam logic [31:0] InsnEcall = 32'h0000_0073;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with valid/ready handshake toward decode.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : capture insn_i/pc_i and mark valid
//   flush_i       : drop the held entry (wins over load_i)
//   ready_i       : decode accepts the held entry this cycle
//   insn_i, pc_i  : instruction and its word index to capture
//   valid_o       : entry is valid
//   insn_o, pc_o  : held instruction and its word index
module if_id_reg
  import rv_core_pkg::*;
#(
  parameter int unsigned PC_W = DefaultPcW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            ready_i,
  input  logic [31:0]     insn_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            valid_o,
  output logic [31:0]     insn_o,
  output logic [PC_W-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [31:0]     insn_q, insn_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    insn_d  = insn_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      insn_d  = insn_i;
      pc_d    = pc_i;
    end else if (valid_q && ready_i) begin
      // Drained with nothing new behind it.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      insn_q  <= InsnNop;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      insn_q  <= insn_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign insn_o  = insn_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: PC sequencing, fetch FSM and the IF/ID register.
// pc_out addresses a combinational instruction memory; the returned insn_in is
// captured into IF/ID, so an instruction appears on id_insn one cycle after its
// index is on pc_out. Redirects flush IF/ID and retarget the PC.
// Optional feature (macro FETCH_HALT_EN): fetching ECALL stops fetch in HALT
// until a redirect or reset; without it halted is tied 0.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   pc_out                       : word index to instruction memory
//   insn_in                      : instruction at pc_out
//   redirect_valid, redirect_pc  : branch/jump redirect from execute
//   id_valid, id_ready           : IF/ID handshake with decode
//   id_insn, id_pc               : IF/ID contents
//   halted                       : fetch stopped on ECALL
module pc_fetch
  import rv_core_pkg::*;
#(
  parameter int unsigned     PC_W     = DefaultPcW,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] pc_out,
  input  logic [31:0]     insn_in,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_insn,
  output logic [PC_W-1:0] id_pc,
  output logic            halted
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic active;     // RUN or HALT: redirects are honoured
  logic redirect;
  logic fetch_load;
  logic flush;

  always_comb begin
    active     = (state_q != StIdle);
    redirect   = active && redirect_valid;
    fetch_load = (state_q == StRun) && !redirect_valid && (!id_valid || id_ready);
    flush      = redirect;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state and next PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: state_d = StRun;
      StRun, StHalt: begin
        if (redirect) begin
          state_d = StRun;
          pc_d    = redirect_pc;
        end else if (fetch_load) begin
          pc_d = pc_q + 1'b1;  // wraps modulo 2^PC_W
`ifdef FETCH_HALT_EN
          if (insn_in == InsnEcall) state_d = StHalt;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    pc_out = pc_q;
`ifdef FETCH_HALT_EN
    halted = (state_q == StHalt);
`else
    halted = 1'b0;
`endif
  end

  if_id_reg #(
    .PC_W(PC_W)
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (fetch_load),
    .flush_i(flush),
    .ready_i(id_ready),
    .insn_i (insn_in),
    .pc_i   (pc_q),
    .valid_o(id_valid),
    .insn_o (id_insn),
    .pc_o   (id_pc)
  );

endmodule
